tl_write_back_pipe: RTL

Registered MIPS write-back stage: holds the MEM/WB pipeline register and produces the register-file write port (data, address, enable) from it. Adds sub-word load extraction with sign/zero extension, a link-address source for JAL/JALR, stall/flush control, a retired-instruction counter and a sticky halt state. Sits between the data-memory stage and the register bank; its outputs also feed the forwarding unit.

---
 rtl/tl_write_back_pipe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tl_write_back_pipe.sv
// rtl/tl_write_back_pipe.sv - MIPS write-back stage: MEM/WB register, load extraction, retire counter, halt
module tl_write_back_pipe #(
  parameter int len                  = 32,
  parameter int NB_CTRL_WB           = 3,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int NB_LOAD_MODE         = 3,
  parameter int NB_COUNT             = 32
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_valid,
  input  logic                            i_stall,
  input  logic                            i_flush,
  input  logic [len-1:0]                  i_read_data,
  input  logic [len-1:0]                  i_result_alu,
  input  logic [len-1:0]                  i_pc_link,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_LOAD_MODE-1:0]         i_load_mode,
  input  logic [1:0]                      i_byte_offset,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  input  logic                            i_halt,
  output logic [len-1:0]                  o_write_data,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic                            o_RegWrite,
  output logic [NB_COUNT-1:0]             o_retired_count,
  output logic                            o_halted
);

  localparam logic [NB_LOAD_MODE-1:0] LM_LB  = NB_LOAD_MODE'(3'b000);
  localparam logic [NB_LOAD_MODE-1:0] LM_LH  = NB_LOAD_MODE'(3'b001);
  localparam logic [NB_LOAD_MODE-1:0] LM_LBU = NB_LOAD_MODE'(3'b100);
  localparam logic [NB_LOAD_MODE-1:0] LM_LHU = NB_LOAD_MODE'(3'b101);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

  state_e state_q, state_d;

  logic                            valid_q, valid_d;
  logic [NB_CTRL_WB-1:0]           ctrl_q, ctrl_d;
  logic [NB_LOAD_MODE-1:0]         mode_q, mode_d;
  logic [1:0]                      off_q, off_d;
  logic [NB_ADDRESS_REGISTROS-1:0] wreg_q, wreg_d;
  logic                            halt_q, halt_d;
  logic [len-1:0]                  rdata_q, rdata_d;
  logic [len-1:0]                  alu_q, alu_d;
  logic [len-1:0]                  link_q, link_d;
  logic [NB_COUNT-1:0]             cnt_q, cnt_d;

  logic           capture;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [len-1:0] ld_data;

  assign capture = (state_q == ST_RUN) && !i_flush && !i_stall;

  // HALTED and flush both force a bubble; stall only holds when neither applies
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    mode_d  = mode_q;
    off_d   = off_q;
    wreg_d  = wreg_q;
    halt_d  = halt_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    link_d  = link_q;
    cnt_d   = cnt_q;
    if (state_q == ST_HALTED || i_flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      mode_d  = '0;
      off_d   = '0;
      wreg_d  = '0;
      halt_d  = 1'b0;
      rdata_d = '0;
      alu_d   = '0;
      link_d  = '0;
    end else if (capture) begin
      valid_d = i_valid;
      ctrl_d  = i_ctrl_wb;
      mode_d  = i_load_mode;
      off_d   = i_byte_offset;
      wreg_d  = i_write_reg;
      halt_d  = i_halt;
      rdata_d = i_read_data;
      alu_d   = i_result_alu;
      link_d  = i_pc_link;
      if (i_valid) begin
        cnt_d = cnt_q + NB_COUNT'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (valid_q && halt_q) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      mode_q  <= '0;
      off_q   <= '0;
      wreg_q  <= '0;
      halt_q  <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
      link_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      mode_q  <= mode_d;
      off_q   <= off_d;
      wreg_q  <= wreg_d;
      halt_q  <= halt_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      link_q  <= link_d;
      cnt_q   <= cnt_d;
    end
  end

  // Little-endian sub-word pick; halfword ignores the low offset bit
  always_comb begin
    ld_byte = rdata_q[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (mode_q)
      LM_LB:   ld_data = {{(len-8){ld_byte[7]}}, ld_byte};
      LM_LBU:  ld_data = {{(len-8){1'b0}}, ld_byte};
      LM_LH:   ld_data = {{(len-16){ld_half[15]}}, ld_half};
      LM_LHU:  ld_data = {{(len-16){1'b0}}, ld_half};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    case (ctrl_q[2:1])
      2'b01:   o_write_data = ld_data;
      2'b10:   o_write_data = link_q;
      default: o_write_data = alu_q;
    endcase
  end

  assign o_write_reg     = wreg_q;
  assign o_RegWrite      = valid_q && ctrl_q[0] && (wreg_q != '0) && !halt_q && (state_q == ST_RUN);
  assign o_retired_count = cnt_q;
  assign o_halted        = (state_q == ST_HALTED);

endmodule
